// File: rtl/pas_trit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pas_trit_pkg
//  Brief    : Shared balanced-ternary gate code type, code constants and the
//             code-to-digit helper used by the trit stream consumers.
//  Revision : 1.0 - initial release
// ============================================================================
package pas_trit_pkg;

   typedef logic [1:0] trit_t;

   localparam trit_t TRIT_SINK    = 2'b00;
   localparam trit_t TRIT_NEUTRAL = 2'b01;
   localparam trit_t TRIT_SOURCE  = 2'b10;
   localparam trit_t TRIT_INVALID = 2'b11;

   // Map a gate code to its unsigned base-3 digit (sink=0, neutral=1, source=2).
   function automatic logic [1:0] trit_digit(input trit_t code);
      logic [1:0] d;
      case (code)
         TRIT_SINK:    d = 2'd0;
         TRIT_NEUTRAL: d = 2'd1;
         TRIT_SOURCE:  d = 2'd2;
         default:      d = 2'd0;
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pas_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pas_sync_fifo
//  Brief    : Small synchronous FIFO with pointer-plus-count bookkeeping and
//             registered full/empty flags. Head data reads as zero when empty.
//  Revision : 1.0 - initial release
// ============================================================================
module pas_sync_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = $clog2(DEPTH + 1);
   localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_CW-1:0]  r_count;
   logic             r_full;
   logic             r_empty;

   logic             w_do_push;
   logic             w_do_pop;
   logic [c_CW-1:0]  w_count_n;

   // Guard the handshakes against overflow/underflow and form the next occupancy.
   always_comb begin
      w_do_push = push && !r_full;
      w_do_pop  = pop && !r_empty;
      w_count_n = r_count;
      if (w_do_push && !w_do_pop) begin
         w_count_n = r_count + c_CW'(1);
      end else if (w_do_pop && !w_do_push) begin
         w_count_n = r_count - c_CW'(1);
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
         r_count <= w_count_n;
         r_full  <= (w_count_n == c_DEPTH);
         r_empty <= (w_count_n == '0);
      end
   end

   // Storage array needs no reset; the empty flag masks stale entries.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   assign dout  = r_empty ? '0 : r_mem[r_rd_ptr];
   assign full  = r_full;
   assign empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/pas_trit_packer.sv
`default_nettype none
// ============================================================================
//  Module   : pas_trit_packer
//  Brief    : Receiver for the ternary sorting stream. Packs gate codes into
//             base-3 words (first trit least significant), buffers them in an
//             output FIFO, keeps saturating sink/source tallies and a sticky
//             invalid-code flag.
//  Revision : 1.0 - initial release
// ============================================================================
module pas_trit_packer
   import pas_trit_pkg::*;
#(
   parameter int TRITS_PER_WORD = 5,
   parameter int WORD_W         = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int CNT_W          = 16
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  gate_valid,
   input  logic [1:0]                            gate_code,
   output logic                                  gate_ready,
   input  logic                                  flush,
   output logic                                  word_valid,
   output logic [WORD_W-1:0]                     word_data,
   output logic [$clog2(TRITS_PER_WORD+1)-1:0]   word_trits,
   input  logic                                  word_ready,
   output logic [CNT_W-1:0]                      sink_count,
   output logic [CNT_W-1:0]                      source_count,
   output logic                                  err_invalid,
   input  logic                                  clear_err
);

   localparam int c_TW    = $clog2(TRITS_PER_WORD + 1);
   localparam int c_ACC_W = WORD_W + 2;
   localparam logic [c_TW-1:0]  c_TRITS   = c_TW'(TRITS_PER_WORD);
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   logic [c_ACC_W-1:0] r_acc;
   logic [c_ACC_W-1:0] r_wt;
   logic [c_TW-1:0]    r_cnt;
   logic               r_pending;
   logic               r_run;
   logic [CNT_W-1:0]   r_sink;
   logic [CNT_W-1:0]   r_src;
   logic               r_err;

   logic               w_accept;
   logic               w_take;
   logic [1:0]         w_digit;
   logic [c_ACC_W-1:0] w_term;
   logic [c_ACC_W-1:0] w_acc_n;
   logic [c_ACC_W-1:0] w_wt_n;
   logic [c_TW-1:0]    w_cnt_n;
   logic               w_pend;
   logic               w_pend_n;
   logic               w_push;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic [c_TW+WORD_W-1:0] w_fifo_dout;

   // Ready depends only on registered state: out of reset and FIFO not full.
   assign gate_ready = r_run && !w_fifo_full;

   // Fold the incoming trit in first, then decide whether a word leaves.
   always_comb begin
      w_accept = gate_valid && gate_ready;
      w_take   = w_accept && (gate_code != TRIT_INVALID);
      w_digit  = trit_digit(gate_code);
      w_term   = (w_digit == 2'd2) ? (r_wt << 1) :
                 (w_digit == 2'd1) ? r_wt : '0;
      w_acc_n  = w_take ? (r_acc + w_term) : r_acc;
      w_wt_n   = w_take ? ((r_wt << 1) + r_wt) : r_wt;
      w_cnt_n  = w_take ? (r_cnt + c_TW'(1)) : r_cnt;
      w_pend   = r_pending || flush;
      w_pend_n = w_pend;
      w_push   = 1'b0;
      if (w_take && (w_cnt_n == c_TRITS)) begin
         w_push   = 1'b1;
         w_pend_n = 1'b0;
      end else if (w_pend) begin
         if (w_cnt_n == '0) begin
            w_pend_n = 1'b0;
         end else if (!w_fifo_full) begin
            w_push   = 1'b1;
            w_pend_n = 1'b0;
         end
      end
   end

   // Packing state: restart the word whenever one is pushed.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc     <= '0;
         r_wt      <= c_ACC_W'(1);
         r_cnt     <= '0;
         r_pending <= 1'b0;
         r_run     <= 1'b0;
      end else begin
         r_run     <= 1'b1;
         r_pending <= w_pend_n;
         if (w_push) begin
            r_acc <= '0;
            r_wt  <= c_ACC_W'(1);
            r_cnt <= '0;
         end else begin
            r_acc <= w_acc_n;
            r_wt  <= w_wt_n;
            r_cnt <= w_cnt_n;
         end
      end
   end

   // Saturating tallies and sticky error; a new invalid code beats clear_err.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sink <= '0;
         r_src  <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_take && (gate_code == TRIT_SINK) && (r_sink != c_CNT_MAX)) begin
            r_sink <= r_sink + CNT_W'(1);
         end
         if (w_take && (gate_code == TRIT_SOURCE) && (r_src != c_CNT_MAX)) begin
            r_src <= r_src + CNT_W'(1);
         end
         if (w_accept && (gate_code == TRIT_INVALID)) begin
            r_err <= 1'b1;
         end else if (clear_err) begin
            r_err <= 1'b0;
         end
      end
   end

   pas_sync_fifo #(
      .WIDTH (c_TW + WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .din   ({w_cnt_n, w_acc_n[WORD_W-1:0]}),
      .pop   (word_valid && word_ready),
      .dout  (w_fifo_dout),
      .full  (w_fifo_full),
      .empty (w_fifo_empty)
   );

   assign word_valid   = !w_fifo_empty;
   assign word_data    = w_fifo_dout[WORD_W-1:0];
   assign word_trits   = w_fifo_dout[c_TW+WORD_W-1:WORD_W];
   assign sink_count   = r_sink;
   assign source_count = r_src;
   assign err_invalid  = r_err;

endmodule
`default_nettype wire

// File: doc/pas_trit_packer.md
Name: pas_trit_packer

Overview:
- Receiver end of the Maxwell-daemon ternary sorting stream.
- Accepts balanced-ternary gate codes (sink −1, neutral 0, source +1) over a valid/ready handshake.
- Packs TRITS_PER_WORD trits into one binary word (base-3, first trit least significant) and buffers packed words in a small output FIFO.
- Keeps saturating sink/source tallies and a sticky invalid-code flag for the energy ledger and debug.

Parameters:
- TRITS_PER_WORD, 5, trits packed per output word; must satisfy 3^TRITS_PER_WORD ≤ 2^WORD_W.
- WORD_W, 8, packed word width.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥ 2.
- CNT_W, 16, width of the tally counters.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- gate_valid  in  1  gate code valid.
- gate_code  in  2  00 sink(−1), 01 neutral(0), 10 source(+1), 11 invalid.
- gate_ready  out  1  packer can accept a code.
- flush  in  1  single-cycle request to emit the partial word.
- word_valid  out  1  FIFO head valid.
- word_data  out  WORD_W  packed value at FIFO head.
- word_trits  out  $clog2(TRITS_PER_WORD+1)  number of valid trits in the head word.
- word_ready  in  1  consumer accepts the head word.
- sink_count  out  CNT_W  accepted sink codes, saturating.
- source_count  out  CNT_W  accepted source codes, saturating.
- err_invalid  out  1  sticky: an 11 code was accepted.
- clear_err  in  1  clears err_invalid.

Behaviour:
- Reset is synchronous and active-high on clk. Reset values:
  - gate_ready=0 during reset, 1 the cycle after.
  - word_valid=0, word_data=0, word_trits=0.
  - sink_count=0, source_count=0, err_invalid=0.
  - Accumulator=0, weight=1, trit count=0, flush_pending=0, FIFO empty.
- Reset mid-word discards the partial word and all FIFO contents.
- Handshake: a code is accepted when gate_valid && gate_ready.
  - gate_ready = !fifo_full, taken from registered FIFO occupancy only. There is no combinational path from word_ready or gate_valid to gate_ready.
- Digit map: d = 0/1/2 for codes 00/01/10.
  - On an accepted valid code: acc += d*weight; weight *= 3 (computed as (w<<1)+w); count += 1.
  - Accumulator and weight widths are WORD_W+2 so the final multiply cannot overflow.
- Word completion: when the accepted trit makes count == TRITS_PER_WORD, the final value is pushed that same cycle with word_trits=TRITS_PER_WORD, and acc/weight/count return to 0/1/0.
  - word_valid rises the next cycle, so latency from the last trit to output is 1 cycle.
- Invalid code 11: the handshake still completes. The trit is dropped (acc/count unchanged), err_invalid is set, and tallies are unchanged.
- clear_err clears err_invalid. If clear_err and an invalid accept occur in the same cycle, the set wins.
- Tallies: sink_count increments on accepted 00, source_count on accepted 10. Both saturate at 2^CNT_W−1 and never wrap.
- Flush:
  - flush sets flush_pending.
  - While pending, count>0 and the FIFO is not full, the partial word is pushed with word_trits=count; acc/weight/count and pending are cleared.
  - If count==0, pending clears with no push.
  - flush in the same cycle as an accepted trit: the trit is included first. If that trit completes the word, the full word is pushed and pending clears with no extra push. Otherwise the partial word, including that trit, is pushed that cycle if the FIFO has space.
  - While the FIFO is full, flush stays pending.
- FIFO: push and pop may occur in the same cycle.
  - Pop when word_valid && word_ready.
  - word_data/word_trits hold stable while word_valid && !word_ready.
  - Push is never attempted when full. Full/empty come from a pointer-plus-count scheme; pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package pas_trit_pkg holds:
  - The code constants TRIT_SINK=2'b00, TRIT_NEUTRAL=2'b01, TRIT_SOURCE=2'b10, TRIT_INVALID=2'b11.
  - The function trit_digit(code) returning 0..2.
  - The trit type shared with pas_daemons consumers.
- One sub-module, pas_sync_fifo (parameterised width/depth, registered full/empty), stores {word_trits, word_data}.
- Packing, flush and tally logic stay in pas_trit_packer.

Test Plan:
- Five accepted 10 codes, word_ready=1 → one word, word_data=242, word_trits=5, one cycle after the 5th accept; source_count=5.
- Codes 01,10,00,01,10 → word_data=1+6+0+27+162=196, word_trits=5; sink_count=1, source_count=2.
- Codes 10,01 then flush pulse → word_data=5, word_trits=2. A following flush with count==0 produces no word.
- word_ready=0 with 20 codes streamed:
  - 4 words fill the FIFO and gate_ready drops the cycle after the 4th push; the 21st code stalls and is not lost.
  - One word_ready pulse pops 1 word; gate_ready returns to 1 the next cycle.
- Codes 10,11,10,10,10,10 → one word 242 with word_trits=5; err_invalid=1.
  - clear_err alone clears it.
  - clear_err in the same cycle as a new 11 leaves err_invalid=1.
- Three 10 codes, then reset for 1 cycle, then five 01 codes → only word_data=121, word_trits=5 appears; tallies restart from 0 (source_count=0).
